muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle multiply/divide sequencer that replaces the single-cycle `Mult/Multu/Div/Divu` paths in the EX stage. It accepts one operation from EX and holds the pipeline with a stall request while it iterates. It then writes the 64-bit product or the quotient/remainder pair into the HI/LO register file through the same `whi/wlo/wHiData/wLoData` write port EX already uses. Exceptions from the CP0 logic cancel an operation in flight.

## Interface
- `WIDTH`, 32, operand width; HI/LO each `WIDTH` bits.
- `clk` input 1, rising-edge clock.
- `rst` input 1, reset, synchronous, active-high.
- `start` input 1, EX holds a mult/div op this cycle.
- `opsel` input 2, 00 Mult, 01 Multu, 10 Div, 11 Divu.
- `opa` input WIDTH, rs value (dividend / multiplicand).
- `opb` input WIDTH, rt value (divisor / multiplier).
- `flush` input 1, exception taken (excptype nonzero); abort.
- `stallReq` output 1, freeze PC/IF/ID/EX.
- `busy` output 1, state is not IDLE.
- `whi`, `wlo` output 1, HI/LO write enables (pulse).
- `wHiData`, `wLoData` output WIDTH, HI/LO write data.

## Operation
- FSM states: IDLE, PREP, CALC, FIX.
- IDLE: `start`=1 and `flush`=0 -> latch `opsel`, `opa`, `opb` -> PREP.
- PREP: for signed ops, form magnitudes |opa| and |opb|, and record the result signs: product/quotient sign = sign(opa) XOR sign(opb); remainder sign = sign(opa). Clear the 6-bit iteration counter and the accumulators.
  - Div/Divu with opb==0 -> FIX with HI=opa, LO=all-ones, skipping CALC.
  - Otherwise -> CALC.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
- CALC, divide: restoring division, one quotient bit per cycle; remainder register is WIDTH+1 bits.
- CALC ends when the counter reaches WIDTH-1, then -> FIX.
- FIX: apply two's-complement negation per the recorded signs. Unsigned ops never negate.
  - Assert `whi`=`wlo`=1 with the results for exactly this cycle, then -> IDLE.
  - Multiply: HI = upper word, LO = lower word.
  - Divide: HI = remainder, LO = quotient.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude path with no special case.
- `flush`=1 in any state: next state IDLE, `whi`/`wlo` forced 0 in that cycle, latched data discarded. HI/LO are never partially written.
- `start` while not IDLE is ignored; EX is stalled and holds the same instruction.
- `flush` and `start` together in IDLE: flush wins, nothing is latched.

## Timing
- Reset: state IDLE, counter 0, all accumulators 0.
- Output values under reset: `stallReq`=0, `busy`=0, `whi`=0, `wlo`=0, `wHiData`=0, `wLoData`=0.
- `stallReq` is combinational: (IDLE & start & ~flush) | PREP | CALC. It is 0 in FIX so EX advances as HI/LO are written.
- Normal latency, with start sampled at cycle T:
  - PREP at T+1.
  - CALC from T+2 to T+1+WIDTH (32 cycles).
  - FIX at T+2+WIDTH, i.e. T+34; HI/LO are updated at the end of T+34.
- Divide-by-zero latency: FIX at T+2.
- `stallReq` is high from T through T+33, which is 34 cycles.
- A following `Mfhi`/`Mflo` reaches EX at T+35 or later and sees the new HI/LO. No forwarding from this block is required.
- A back-to-back `start` is accepted in the IDLE cycle right after FIX.
- `busy` is registered: high from T+1 through FIX.
- `wHiData`/`wLoData` are 0 whenever `whi`/`wlo` are 0.

## Test plan
- Mult, opa=0xFFFFFFFF, opb=2 -> at T+34: whi=wlo=1, HI=0xFFFFFFFF, LO=0xFFFFFFFE; stallReq high for exactly 34 cycles.
- Multu, same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- Div -7/2 (0xFFFFFFF9, 2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divu 100/7 -> LO=0x0000000E, HI=0x00000002.
- Div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divu 5/0 -> at T+2: HI=5, LO=0xFFFFFFFF; stallReq high for only 2 cycles.
- Flush at T+10 of a Mult -> IDLE at T+11, no whi/wlo pulse at any time. A new Divu started at T+11 completes correctly at T+45.
- rst asserted mid-CALC -> next cycle all outputs 0 and state IDLE.

Source files
------------

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer for the EX stage: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, signs fixed up in a final cycle before the HI/LO write.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       opsel,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    output logic             stallReq,
    output logic             busy,
    output logic             whi,
    output logic             wlo,
    output logic [WIDTH-1:0] wHiData,
    output logic [WIDTH-1:0] wLoData
);

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_e;

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [5:0]           cnt_q, cnt_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;

    logic                 is_div, is_signed;
    logic [WIDTH:0]       msum, shifted;
    logic [2*WIDTH-1:0]   prod;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                             input logic en);
        if (en && v[WIDTH-1])
            mag = ~v + WIDTH'(1);
        else
            mag = v;
    endfunction

    function automatic logic [WIDTH-1:0] negw(input logic [WIDTH-1:0] v, input logic en);
        negw = en ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2w(input logic [2*WIDTH-1:0] v, input logic en);
        neg2w = en ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = PREP;
            PREP: state_d = (is_div && (b_q == '0)) ? FIX : CALC;
            CALC: if (cnt_q == LAST) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Datapath next values
    always_comb begin
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d = opsel;
                    a_d  = opa;
                    b_d  = opb;
                end
            end
            PREP: begin
                a_d    = mag(a_q, is_signed);
                b_d    = mag(b_q, is_signed);
                qneg_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                rneg_d = is_signed & a_q[WIDTH-1];
                cnt_d  = '0;
                acc_d  = '0;
                rem_d  = '0;
                quo_d  = is_div ? mag(a_q, is_signed) : '0;
                // Divide by zero bypasses CALC: HI gets the raw dividend, LO all ones
                if (is_div && (b_q == '0)) begin
                    rem_d  = {1'b0, a_q};
                    quo_d  = '1;
                    qneg_d = 1'b0;
                    rneg_d = 1'b0;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 6'd1;
                if (is_div) begin
                    if (shifted >= {1'b0, b_q}) begin
                        rem_d = shifted - {1'b0, b_q};
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted;
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {msum, acc_q[WIDTH-1:1]};
                    b_d   = b_q >> 1;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        stallReq = 1'b0;
        whi      = 1'b0;
        wlo      = 1'b0;
        wHiData  = '0;
        wLoData  = '0;
        prod     = neg2w(acc_q, qneg_q);
        busy     = (state_q != IDLE) && !rst;
        unique case (state_q)
            IDLE:    stallReq = start & ~flush;
            PREP:    stallReq = 1'b1;
            CALC:    stallReq = 1'b1;
            FIX: begin
                if (!flush) begin
                    whi = 1'b1;
                    wlo = 1'b1;
                    if (is_div) begin
                        wHiData = negw(rem_q[WIDTH-1:0], rneg_q);
                        wLoData = negw(quo_q, qneg_q);
                    end else begin
                        wHiData = prod[2*WIDTH-1:WIDTH];
                        wLoData = prod[WIDTH-1:0];
                    end
                end
            end
            default: ;
        endcase
        if (rst) begin
            stallReq = 1'b0;
            whi      = 1'b0;
            wlo      = 1'b0;
            wHiData  = '0;
            wLoData  = '0;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: results, latency, stall window, flush, reset and back-to-back ops.
module tb_muldiv_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst, start, flush;
    logic [1:0]       opsel;
    logic [WIDTH-1:0] opa, opb;
    logic             stallReq, busy, whi, wlo;
    logic [WIDTH-1:0] wHiData, wLoData;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .opsel(opsel), .opa(opa), .opb(opb),
        .flush(flush), .stallReq(stallReq), .busy(busy), .whi(whi), .wlo(wlo),
        .wHiData(wHiData), .wLoData(wLoData)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; opsel = 2'b00; opa = '0; opb = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (stallReq !== 1'b0) begin errors++; $display("FAIL reset stallReq: got %b expected 0", stallReq); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++; if (whi !== 1'b0) begin errors++; $display("FAIL reset whi: got %b expected 0", whi); end
        checks++; if (wlo !== 1'b0) begin errors++; $display("FAIL reset wlo: got %b expected 0", wlo); end
        checks++; if (wHiData !== 32'h0) begin errors++; $display("FAIL reset wHiData: got %h expected 0", wHiData); end
        checks++; if (wLoData !== 32'h0) begin errors++; $display("FAIL reset wLoData: got %h expected 0", wLoData); end
        rst = 1'b0;
    endtask

    // Issues one op at cycle 0; an optional extra start at cycle noise must be ignored
    task automatic test_op(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                           input int ewcyc, input int estall, input int noise);
        int wcyc, npulse, nstall, nleak, nwlo;
        logic [31:0] hi, lo;
        logic busy1, busyf, busya;
        wcyc = -1; npulse = 0; nstall = 0; nleak = 0; nwlo = 0;
        hi = '0; lo = '0; busy1 = 1'b0; busyf = 1'b0; busya = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            start = (c == 0) || (c == noise);
            opsel = (c == 0) ? op : 2'b11;
            opa   = (c == 0) ? a : 32'd123;
            opb   = (c == 0) ? b : 32'd456;
            #1;
            if (stallReq) nstall++;
            if (wlo !== whi) nwlo++;
            if (c == 1) busy1 = busy;
            if (c == ewcyc) busyf = busy;
            if (c == ewcyc + 1) busya = busy;
            if (whi) begin
                npulse++;
                if (wcyc < 0) begin wcyc = c; hi = wHiData; lo = wLoData; end
            end else if (wHiData != 0 || wLoData != 0) nleak++;
        end
        start = 1'b0;
        checks++; if (wcyc != ewcyc) begin errors++; $display("FAIL %s write cycle: got %0d expected %0d", name, wcyc, ewcyc); end
        checks++; if (npulse != 1) begin errors++; $display("FAIL %s whi pulses: got %0d expected 1", name, npulse); end
        checks++; if (hi !== ehi) begin errors++; $display("FAIL %s HI: got %h expected %h", name, hi, ehi); end
        checks++; if (lo !== elo) begin errors++; $display("FAIL %s LO: got %h expected %h", name, lo, elo); end
        checks++; if (nstall != estall) begin errors++; $display("FAIL %s stall cycles: got %0d expected %0d", name, nstall, estall); end
        checks++; if (nwlo != 0) begin errors++; $display("FAIL %s wlo!=whi cycles: got %0d expected 0", name, nwlo); end
        checks++; if (nleak != 0) begin errors++; $display("FAIL %s data without write: got %0d expected 0", name, nleak); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL %s busy after start: got %b expected 1", name, busy1); end
        checks++; if (busyf !== 1'b1) begin errors++; $display("FAIL %s busy in FIX: got %b expected 1", name, busyf); end
        checks++; if (busya !== 1'b0) begin errors++; $display("FAIL %s busy after FIX: got %b expected 0", name, busya); end
    endtask

    task automatic test_flush();
        int early, wcyc;
        logic [31:0] hi, lo;
        logic busy10, busy11, stall_fs;
        early = 0; wcyc = -1; hi = '0; lo = '0; busy10 = 1'b0; busy11 = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            start = (c == 0) || (c == 11);
            flush = (c == 10);
            opsel = (c == 0) ? 2'b00 : 2'b11;
            opa   = (c == 0) ? 32'hFFFF_FFFF : 32'd100;
            opb   = (c == 0) ? 32'd2 : 32'd7;
            #1;
            if (c == 10) busy10 = busy;
            if (c == 11) busy11 = busy;
            if (whi) begin
                if (c < 11) early++;
                else if (wcyc < 0) begin wcyc = c; hi = wHiData; lo = wLoData; end
            end
        end
        start = 1'b0; flush = 1'b0;
        checks++; if (early != 0) begin errors++; $display("FAIL flush early write: got %0d expected 0", early); end
        checks++; if (busy10 !== 1'b1) begin errors++; $display("FAIL flush busy before: got %b expected 1", busy10); end
        checks++; if (busy11 !== 1'b0) begin errors++; $display("FAIL flush busy after: got %b expected 0", busy11); end
        checks++; if (wcyc != 45) begin errors++; $display("FAIL flush restart cycle: got %0d expected 45", wcyc); end
        checks++; if (hi !== 32'h2) begin errors++; $display("FAIL flush restart HI: got %h expected 00000002", hi); end
        checks++; if (lo !== 32'hE) begin errors++; $display("FAIL flush restart LO: got %h expected 0000000e", lo); end

        // Flush and start together in IDLE: nothing may be accepted
        early = 0; stall_fs = 1'b1; busy11 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = (c == 0); flush = (c == 0);
            opsel = 2'b11; opa = 32'd9; opb = 32'd3;
            #1;
            if (c == 0) stall_fs = stallReq;
            if (c == 1) busy11 = busy;
            if (whi) early++;
        end
        start = 1'b0; flush = 1'b0;
        checks++; if (stall_fs !== 1'b0) begin errors++; $display("FAIL flush+start stallReq: got %b expected 0", stall_fs); end
        checks++; if (busy11 !== 1'b0) begin errors++; $display("FAIL flush+start busy: got %b expected 0", busy11); end
        checks++; if (early != 0) begin errors++; $display("FAIL flush+start write: got %0d expected 0", early); end
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        logic [31:0] hi1, lo1, hi2, lo2;
        c1 = -1; c2 = -1; hi1 = '0; lo1 = '0; hi2 = '0; lo2 = '0;
        for (int c = 0; c < 75; c++) begin
            @(negedge clk);
            start = (c == 0) || (c == 35);
            opsel = (c == 0) ? 2'b11 : 2'b10;
            opa   = (c == 0) ? 32'd100 : 32'hFFFF_FFF9;
            opb   = (c == 0) ? 32'd7 : 32'd2;
            #1;
            if (whi) begin
                if (c1 < 0) begin c1 = c; hi1 = wHiData; lo1 = wLoData; end
                else if (c2 < 0) begin c2 = c; hi2 = wHiData; lo2 = wLoData; end
            end
        end
        start = 1'b0;
        checks++; if (c1 != 34) begin errors++; $display("FAIL b2b first cycle: got %0d expected 34", c1); end
        checks++; if ({hi1, lo1} !== {32'h2, 32'hE}) begin errors++; $display("FAIL b2b first HI/LO: got %h/%h expected 00000002/0000000e", hi1, lo1); end
        checks++; if (c2 != 69) begin errors++; $display("FAIL b2b second cycle: got %0d expected 69", c2); end
        checks++; if ({hi2, lo2} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL b2b second HI/LO: got %h/%h expected ffffffff/fffffffd", hi2, lo2); end
    endtask

    task automatic test_reset_mid();
        int late;
        logic [3:0] o11;
        logic [63:0] d11;
        late = 0; o11 = 4'hF; d11 = '1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            start = (c == 0);
            rst   = (c == 10);
            opsel = 2'b00; opa = 32'hFFFF_FFFF; opb = 32'd2;
            #1;
            if (c == 11) begin o11 = {stallReq, busy, whi, wlo}; d11 = {wHiData, wLoData}; end
            if (whi) late++;
        end
        start = 1'b0; rst = 1'b0;
        checks++; if (o11 !== 4'b0000) begin errors++; $display("FAIL rst mid stall/busy/whi/wlo: got %b expected 0000", o11); end
        checks++; if (d11 !== 64'h0) begin errors++; $display("FAIL rst mid data: got %h expected 0", d11); end
        checks++; if (late != 0) begin errors++; $display("FAIL rst mid write after reset: got %0d expected 0", late); end
    endtask

    initial begin
        test_reset();
        test_op("mult_neg1x2",   2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 34, -1);
        test_op("multu_ffx2",    2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 34, 34, 5);
        test_op("mult_neg3xneg5",2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'h0000_000F, 34, 34, 20);
        test_op("multu_max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34, 34, -1);
        test_op("div_neg7by2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 34, -1);
        test_op("div_7byneg2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34, 34, -1);
        test_op("divu_100by7",   2'b11, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 34, 34, 12);
        test_op("div_overflow",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34, 34, -1);
        test_op("divu_5by0",     2'b11, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 2, 2, -1);
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
